// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared owner encoding, access sizes and default FIFO depth for the memory arbiter
package cpu_mem_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/owner_fifo.sv
// owner_fifo: DEPTH x 1-bit in-order FIFO recording which master owns each outstanding request
module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (PTR_W+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // pointers wrap naturally at DEPTH; count tracks occupancy from registered state only
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one like-SRAM slave between fetch and data masters with in-order response routing
module sram_req_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    logic   lock_valid, lock_valid_nxt;
    owner_t lock_owner, lock_owner_nxt;
    owner_t grant;
    logic   use_lock, sel_inst, sel_data;
    logic   full, empty, push, pop, head_bit;
    owner_t head;

    // grant: a held (locked) request wins, then data over fetch; nothing issues while the FIFO is full
    always_comb begin
        use_lock = lock_valid & (lock_owner == OWN_DATA ? data_sram_req : inst_sram_req);
        grant    = use_lock ? lock_owner : (data_sram_req ? OWN_DATA : OWN_INST);
        mem_req  = (use_lock | data_sram_req | inst_sram_req) & ~full;
        sel_data = mem_req & (grant == OWN_DATA);
        sel_inst = mem_req & (grant == OWN_INST);
    end

    // request fields from the granted master, zero when nothing is issued
    always_comb begin
        mem_wr    = (sel_data & data_sram_wr) | (sel_inst & inst_sram_wr);
        mem_size  = ({2{sel_data}} & data_sram_size) | ({2{sel_inst}} & inst_sram_size);
        mem_wstrb = ({4{sel_data}} & data_sram_wstrb) | ({4{sel_inst}} & inst_sram_wstrb);
        mem_addr  = ({32{sel_data}} & data_sram_addr) | ({32{sel_inst}} & inst_sram_addr);
        mem_wdata = ({32{sel_data}} & data_sram_wdata) | ({32{sel_inst}} & inst_sram_wdata);
    end

    assign inst_sram_addr_ok = mem_addr_ok & sel_inst;
    assign data_sram_addr_ok = mem_addr_ok & sel_data;
    assign push              = mem_req & mem_addr_ok;
    assign pop               = mem_data_ok & ~empty;
    assign head              = owner_t'(head_bit);
    assign inst_sram_data_ok = pop & (head == OWN_INST);
    assign data_sram_data_ok = pop & (head == OWN_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    // lock next state: a stalled request pins the grant until accepted or withdrawn
    always_comb begin
        lock_valid_nxt = lock_valid;
        lock_owner_nxt = lock_owner;
        if (mem_req) begin
            lock_valid_nxt = ~mem_addr_ok;
            if (~mem_addr_ok) lock_owner_nxt = grant;
        end else if (lock_valid & ~use_lock) begin
            lock_valid_nxt = 1'b0;
        end
    end

    // lock register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_owner <= OWN_INST;
        end else begin
            lock_valid <= lock_valid_nxt;
            lock_owner <= lock_owner_nxt;
        end
    end

    owner_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .head  (head_bit),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed and randomized checks of grant, lock, FIFO-full and response routing
module tb_sram_req_arbiter;
    import cpu_mem_pkg::*;

    localparam int DEPTH = DEF_DEPTH;

    logic        clk = 0, reset = 1;
    logic        inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
    logic [1:0]  inst_sram_size, data_sram_size, mem_size;
    logic [3:0]  inst_sram_wstrb, data_sram_wstrb, mem_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int nerr = 0, nchk = 0;

    // reference: queue of owners of accepted requests (0=inst,1=data), pending master or -1
    int oq[$];
    int pend = -1;
    int e_gnt;
    logic e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok;
    logic [1:0] e_size;
    logic [3:0] e_wstrb;
    logic [31:0] e_addr, e_wdata;

    always #5 clk = ~clk;

    sram_req_arbiter #(.DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic idle();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic model_reset();
        oq.delete();
        pend = -1;
    endtask

    task automatic model_eval();
        bit full;
        full = (oq.size() == DEPTH);
        e_gnt = -1;
        if (pend == 1 && data_sram_req) e_gnt = 1;
        else if (pend == 0 && inst_sram_req) e_gnt = 0;
        else if (data_sram_req) e_gnt = 1;
        else if (inst_sram_req) e_gnt = 0;
        e_req   = (e_gnt >= 0) && !full;
        e_wr    = !e_req ? 1'b0  : e_gnt == 1 ? data_sram_wr    : inst_sram_wr;
        e_size  = !e_req ? 2'd0  : e_gnt == 1 ? data_sram_size  : inst_sram_size;
        e_wstrb = !e_req ? 4'd0  : e_gnt == 1 ? data_sram_wstrb : inst_sram_wstrb;
        e_addr  = !e_req ? 32'd0 : e_gnt == 1 ? data_sram_addr  : inst_sram_addr;
        e_wdata = !e_req ? 32'd0 : e_gnt == 1 ? data_sram_wdata : inst_sram_wdata;
        e_iaok  = e_req && mem_addr_ok && e_gnt == 0;
        e_daok  = e_req && mem_addr_ok && e_gnt == 1;
        e_idok  = mem_data_ok && oq.size() > 0 && oq[0] == 0;
        e_ddok  = mem_data_ok && oq.size() > 0 && oq[0] == 1;
    endtask

    task automatic model_commit();
        if (e_idok || e_ddok) void'(oq.pop_front());
        if (e_req && mem_addr_ok) oq.push_back(e_gnt);
        if (e_req) pend = mem_addr_ok ? -1 : e_gnt;
        else if ((pend == 1 && !data_sram_req) || (pend == 0 && !inst_sram_req)) pend = -1;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        settle();
        nchk++;
        if ({inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, data_sram_addr_ok, data_sram_data_ok,
             data_sram_rdata, mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
            nerr++; $display("FAIL reset_outputs: mem_req=%b mem_addr=%h addr_ok=%b%b data_ok=%b%b, all required 0",
                             mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok);
        end
        model_commit();
    endtask

    task automatic test_single_fetch();
        @(negedge clk); idle();
        inst_sram_req = 1; inst_sram_size = SZ_WORD; inst_sram_wstrb = 4'hf;
        inst_sram_addr = 32'h1c000000; mem_addr_ok = 1;
        settle();
        nchk++;
        if ({inst_sram_addr_ok, data_sram_addr_ok, mem_req} !== 3'b101 || mem_addr !== 32'h1c000000) begin
            nerr++; $display("FAIL fetch_accept: iaok=%b daok=%b mem_req=%b addr=%h, required 1 0 1 1c000000",
                             inst_sram_addr_ok, data_sram_addr_ok, mem_req, mem_addr);
        end
        model_commit();
        @(negedge clk); idle(); settle();
        nchk++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
            nerr++; $display("FAIL fetch_gap: data_ok=%b%b required 00", inst_sram_data_ok, data_sram_data_ok);
        end
        model_commit();
        @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'h02800c0c; settle();
        nchk++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10 || inst_sram_rdata !== 32'h02800c0c) begin
            nerr++; $display("FAIL fetch_resp: data_ok i/d=%b%b rdata=%h, required 10 02800c0c",
                             inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
        end
        model_commit();
    endtask

    task automatic test_collision();
        @(negedge clk); idle();
        inst_sram_req = 1; inst_sram_addr = 32'h0000_1000;
        data_sram_req = 1; data_sram_addr = 32'h0000_2000; data_sram_wr = 1; data_sram_wdata = 32'hcafe_f00d;
        mem_addr_ok = 1; settle();
        nchk++;
        if (mem_addr !== 32'h2000 || {data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10 || mem_wr !== 1'b1) begin
            nerr++; $display("FAIL collide_data_first: addr=%h daok=%b iaok=%b wr=%b, required 2000 1 0 1",
                             mem_addr, data_sram_addr_ok, inst_sram_addr_ok, mem_wr);
        end
        model_commit();
        @(negedge clk); idle();
        inst_sram_req = 1; inst_sram_addr = 32'h0000_1000; mem_addr_ok = 1; settle();
        nchk++;
        if (mem_addr !== 32'h1000 || {data_sram_addr_ok, inst_sram_addr_ok} !== 2'b01) begin
            nerr++; $display("FAIL collide_inst_next: addr=%h daok=%b iaok=%b, required 1000 0 1",
                             mem_addr, data_sram_addr_ok, inst_sram_addr_ok);
        end
        model_commit();
        @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'h1111_1111; settle();
        nchk++;
        if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b10 || data_sram_rdata !== 32'h1111_1111) begin
            nerr++; $display("FAIL collide_r1: data_ok d/i=%b%b rdata=%h, required 10 11111111",
                             data_sram_data_ok, inst_sram_data_ok, data_sram_rdata);
        end
        model_commit();
        @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'h2222_2222; settle();
        nchk++;
        if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b01 || inst_sram_rdata !== 32'h2222_2222) begin
            nerr++; $display("FAIL collide_r2: data_ok d/i=%b%b rdata=%h, required 01 22222222",
                             data_sram_data_ok, inst_sram_data_ok, inst_sram_rdata);
        end
        model_commit();
    endtask

    task automatic test_lock_hold();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); idle();
            inst_sram_req = 1; inst_sram_addr = 32'h1c00_0040;
            data_sram_req = (c >= 1); data_sram_addr = 32'h8000_0100;
            mem_addr_ok = (c == 3); settle();
            nchk++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h1c00_0040 || data_sram_addr_ok !== 1'b0 ||
                inst_sram_addr_ok !== (c == 3)) begin
                nerr++; $display("FAIL lock_hold c%0d: req=%b addr=%h daok=%b iaok=%b, required 1 1c000040 0 %0d",
                                 c, mem_req, mem_addr, data_sram_addr_ok, inst_sram_addr_ok, c == 3);
            end
            model_commit();
        end
        @(negedge clk); idle();
        data_sram_req = 1; data_sram_addr = 32'h8000_0100; mem_addr_ok = 1; settle();
        nchk++;
        if (mem_addr !== 32'h8000_0100 || data_sram_addr_ok !== 1'b1) begin
            nerr++; $display("FAIL lock_release: addr=%h daok=%b, required 80000100 1", mem_addr, data_sram_addr_ok);
        end
        model_commit();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle(); mem_data_ok = 1; settle();
            nchk++;
            if ({inst_sram_data_ok, data_sram_data_ok} !== (k == 0 ? 2'b10 : 2'b01)) begin
                nerr++; $display("FAIL lock_resp%0d: data_ok i/d=%b%b", k, inst_sram_data_ok, data_sram_data_ok);
            end
            model_commit();
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk); idle();
            data_sram_req = 1; data_sram_addr = 32'h100 + 4 * k; mem_addr_ok = 1; settle();
            nchk++;
            if (data_sram_addr_ok !== 1'b1) begin
                nerr++; $display("FAIL full_fill%0d: daok=%b required 1", k, data_sram_addr_ok);
            end
            model_commit();
        end
        @(negedge clk); idle();
        data_sram_req = 1; data_sram_addr = 32'h200; mem_addr_ok = 1; settle();
        nchk++;
        if ({mem_req, data_sram_addr_ok} !== 2'b00) begin
            nerr++; $display("FAIL full_block: req=%b daok=%b required 00", mem_req, data_sram_addr_ok);
        end
        model_commit();
        @(negedge clk); idle();
        data_sram_req = 1; data_sram_addr = 32'h200; mem_addr_ok = 1; mem_data_ok = 1; settle();
        nchk++;
        if ({mem_req, data_sram_addr_ok, data_sram_data_ok} !== 3'b001) begin
            nerr++; $display("FAIL full_pop_same: req=%b daok=%b dok=%b required 001",
                             mem_req, data_sram_addr_ok, data_sram_data_ok);
        end
        model_commit();
        @(negedge clk); idle();
        data_sram_req = 1; data_sram_addr = 32'h200; mem_addr_ok = 1; settle();
        nchk++;
        if ({mem_req, data_sram_addr_ok} !== 2'b11 || mem_addr !== 32'h200) begin
            nerr++; $display("FAIL full_after_pop: req=%b daok=%b addr=%h required 11 200",
                             mem_req, data_sram_addr_ok, mem_addr);
        end
        model_commit();
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk); idle(); mem_data_ok = 1; settle();
            nchk++;
            if (data_sram_data_ok !== 1'b1) begin
                nerr++; $display("FAIL full_drain%0d: dok=%b required 1", k, data_sram_data_ok);
            end
            model_commit();
        end
    endtask

    task automatic test_wrap_mixed();
        logic [1:0] sizes [3];
        int il = 6, dl = 4, n = 0;
        bit ih = 0, dh = 0;
        logic ia_wr, da_wr;
        logic [1:0] ia_sz, da_sz;
        logic [3:0] ia_st, da_st;
        logic [31:0] ia_a, ia_d, da_a, da_d;
        sizes[0] = SZ_BYTE; sizes[1] = SZ_HALF; sizes[2] = SZ_WORD;
        while ((il > 0 || dl > 0 || oq.size() > 0) && n < 400) begin
            @(negedge clk); idle();
            if (!ih) begin
                ia_wr = 0; ia_sz = sizes[$urandom_range(0, 2)]; ia_st = 4'($urandom); ia_a = $urandom; ia_d = $urandom;
            end
            if (!dh) begin
                da_wr = 1'($urandom); da_sz = sizes[$urandom_range(0, 2)]; da_st = 4'($urandom); da_a = $urandom; da_d = $urandom;
            end
            inst_sram_req = il > 0 && (ih || $urandom_range(0, 1) == 1);
            data_sram_req = dl > 0 && (dh || $urandom_range(0, 2) == 0);
            inst_sram_wr = ia_wr; inst_sram_size = ia_sz; inst_sram_wstrb = ia_st;
            inst_sram_addr = ia_a; inst_sram_wdata = ia_d;
            data_sram_wr = da_wr; data_sram_size = da_sz; data_sram_wstrb = da_st;
            data_sram_addr = da_a; data_sram_wdata = da_d;
            mem_addr_ok = $urandom_range(0, 2) != 0;
            mem_data_ok = 1'($urandom);
            mem_rdata = $urandom;
            settle();
            nchk++;
            if ({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
                {e_req, e_wr, e_size, e_wstrb, e_addr, e_wdata}) begin
                nerr++; $display("FAIL rnd_req n%0d: req=%b addr=%h wdata=%h, required %b %h %h",
                                 n, mem_req, mem_addr, mem_wdata, e_req, e_addr, e_wdata);
            end
            nchk++;
            if ({inst_sram_addr_ok, data_sram_addr_ok} !== {e_iaok, e_daok}) begin
                nerr++; $display("FAIL rnd_addr_ok n%0d: i/d=%b%b required %b%b",
                                 n, inst_sram_addr_ok, data_sram_addr_ok, e_iaok, e_daok);
            end
            nchk++;
            if ({inst_sram_data_ok, data_sram_data_ok} !== {e_idok, e_ddok}) begin
                nerr++; $display("FAIL rnd_data_ok n%0d: i/d=%b%b required %b%b",
                                 n, inst_sram_data_ok, data_sram_data_ok, e_idok, e_ddok);
            end
            nchk++;
            if ((inst_sram_data_ok && inst_sram_rdata !== mem_rdata) || (data_sram_data_ok && data_sram_rdata !== mem_rdata)) begin
                nerr++; $display("FAIL rnd_rdata n%0d: i=%h d=%h required %h", n, inst_sram_rdata, data_sram_rdata, mem_rdata);
            end
            if (e_iaok) il--;
            if (e_daok) dl--;
            ih = inst_sram_req && !e_iaok;
            dh = data_sram_req && !e_daok;
            model_commit();
            n++;
        end
        nchk++;
        if (n >= 400) begin
            nerr++; $display("FAIL rnd_timeout: left i=%0d d=%0d outstanding=%0d, required all 0", il, dl, oq.size());
        end
        @(negedge clk); idle(); mem_data_ok = 1; settle();
        nchk++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
            nerr++; $display("FAIL rnd_drained: data_ok=%b%b required 00", inst_sram_data_ok, data_sram_data_ok);
        end
        model_commit();
    endtask

    task automatic test_spurious_reset();
        @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'hdead_beef; settle();
        nchk++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
            nerr++; $display("FAIL spurious: data_ok=%b%b required 00", inst_sram_data_ok, data_sram_data_ok);
        end
        model_commit();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle();
            inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000 + 4 * k; mem_addr_ok = 1; settle();
            model_commit();
        end
        @(negedge clk); idle(); inst_sram_req = 1; reset = 1;
        @(negedge clk); idle(); reset = 0; model_reset(); settle();
        nchk++;
        if ({inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, data_sram_addr_ok, data_sram_data_ok,
             data_sram_rdata, mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
            nerr++; $display("FAIL reset_mid: mem_req=%b addr=%h data_ok=%b%b, all required 0",
                             mem_req, mem_addr, inst_sram_data_ok, data_sram_data_ok);
        end
        nchk++;
        if (u_dut.u_fifo.empty !== 1'b1) begin
            nerr++; $display("FAIL reset_empty: empty=%b required 1", u_dut.u_fifo.empty);
        end
        model_commit();
        @(negedge clk); idle(); mem_data_ok = 1; settle();
        nchk++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
            nerr++; $display("FAIL reset_no_resp: data_ok=%b%b required 00", inst_sram_data_ok, data_sram_data_ok);
        end
        model_commit();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_fetch();
        test_collision();
        test_lock_hold();
        test_full();
        test_wrap_mixed();
        test_wrap_mixed();
        test_spurious_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
